// File: rtl/fpu_wb_regs_if.sv
// Wishbone slave bus bundle between the management-core bus and the FPU register block.
interface fpu_wb_regs_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fpu_wb_regs.sv
// Wishbone register block fronting the FPU: operands, op issue, result/flag capture.
// Defining FPU_WB_IRQ_EN adds the irq output and the CTRL irq_en bit.
//
// state | meaning
// IDLE  | waiting for an OPERATION write with valid=1
// ISSUE | op latched; start pulse is registered out on the following cycle
// WAIT  | pulse issued; waiting for fpu_valid_i to capture result and flags
module fpu_wb_regs #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         rst_l,
    fpu_wb_regs_if.slave wbs,
    output logic [31:0]  fpu_a,
    output logic [31:0]  fpu_b,
    output logic [31:0]  fpu_c,
    output logic [2:0]   fpu_rm,
    output logic [11:0]  fpu_op,
    output logic         fpu_valid_o,
    input  logic [31:0]  fpu_result,
    input  logic [4:0]   fpu_flags,
    input  logic         fpu_valid_i
`ifdef FPU_WB_IRQ_EN
    ,
    output logic         irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        valid_q;
    logic [31:0] reg_a, reg_b, reg_c, reg_result;
    logic [4:0]  reg_flags;
    logic [2:0]  reg_rm;
    logic [11:0] reg_op;
    logic        op_valid;
    logic        done;
    logic        err;
    logic        irq_en;

    logic        req;
    logic        wr;
    logic        busy;
    logic        op_go;
    logic [7:0]  offset;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [11:0] op_new;
    logic [31:0] rdata;

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] nxt,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = nxt[8*i +: 8];
        end
        return res;
    endfunction

    // ack_q gating keeps ack from ever asserting two cycles running
    assign req    = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                    (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    assign wr     = req & wbs.wbs_we_i;
    assign offset = wbs.wbs_adr_i[7:0];
    assign sel    = wbs.wbs_sel_i;
    assign dat    = wbs.wbs_dat_i;
    assign busy   = (state != S_IDLE);
    assign op_new = {sel[1] ? dat[11:8] : reg_op[11:8], sel[0] ? dat[7:0] : reg_op[7:0]};
    assign op_go  = sel[1] & dat[12];

    always_comb begin
        rdata = '0;
        case (offset)
            8'h00:   rdata = reg_a;
            8'h04:   rdata = reg_b;
            8'h08:   rdata = reg_c;
            8'h0C:   rdata = reg_result;
            8'h10:   rdata = {27'd0, reg_flags};
            8'h14:   rdata = {29'd0, err, done, busy};
            8'h18:   rdata = {31'd0, irq_en};
            8'h1C:   rdata = {19'd0, op_valid, reg_op};
            8'h24:   rdata = {29'd0, reg_rm};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_l) begin
            state      <= S_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            valid_q    <= 1'b0;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            reg_result <= '0;
            reg_flags  <= '0;
            reg_rm     <= '0;
            reg_op     <= '0;
            op_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef FPU_WB_IRQ_EN
            irq_en     <= 1'b0;
            irq        <= 1'b0;
`endif
        end else begin
            ack_q    <= req;
            dat_q    <= (req && !wbs.wbs_we_i) ? rdata : '0;
            op_valid <= 1'b0;
            valid_q  <= 1'b0;
            if (wr) begin
                case (offset)
                    8'h00: reg_a <= lane_merge(reg_a, dat, sel);
                    8'h04: reg_b <= lane_merge(reg_b, dat, sel);
                    8'h08: reg_c <= lane_merge(reg_c, dat, sel);
                    8'h18: begin
                        if (sel[0] && dat[1]) begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end
`ifdef FPU_WB_IRQ_EN
                        if (sel[0]) irq_en <= dat[0];
`endif
                    end
                    8'h1C: begin
                        if (!busy) begin
                            reg_op <= op_new;
                            if (op_go) begin
                                op_valid <= 1'b1;
                                done     <= 1'b0;
                                state    <= S_ISSUE;
                            end
                        end else if (op_go) begin
                            err <= 1'b1;
                        end else begin
                            reg_op <= op_new;
                        end
                    end
                    8'h24: if (sel[0]) reg_rm <= dat[2:0];
                    default: ;
                endcase
            end
            // completion is evaluated after the bus write so a same-cycle clear cannot lose it
            case (state)
                S_IDLE: ;
                S_ISSUE: begin
                    valid_q <= 1'b1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_valid_i) begin
                        reg_result <= fpu_result;
                        reg_flags  <= fpu_flags;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef FPU_WB_IRQ_EN
            irq <= done & irq_en;
`endif
        end
    end

`ifndef FPU_WB_IRQ_EN
    assign irq_en = 1'b0;
`endif

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign fpu_a         = reg_a;
    assign fpu_b         = reg_b;
    assign fpu_c         = reg_c;
    assign fpu_rm        = reg_rm;
    assign fpu_op        = reg_op;
    assign fpu_valid_o   = valid_q;

endmodule

// File: tb/tb_fpu_wb_regs.sv
// Bench for fpu_wb_regs: vector table, hand-written FSM corner cases, randomized map traffic.
module tb_fpu_wb_regs;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef FPU_WB_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic [2:0]  fpu_rm;
    logic [11:0] fpu_op;
    logic        fpu_valid_o;
    logic [31:0] fpu_result = '0;
    logic [4:0]  fpu_flags = '0;
    logic        fpu_valid_i = 1'b0;
`ifdef FPU_WB_IRQ_EN
    logic        irq;
`endif

    fpu_wb_regs_if bus();

    fpu_wb_regs #(.BASE_ADR(BASE)) dut (
        .wb_clk_i    (clk),
        .rst_l       (rst_l),
        .wbs         (bus),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_c       (fpu_c),
        .fpu_rm      (fpu_rm),
        .fpu_op      (fpu_op),
        .fpu_valid_o (fpu_valid_o),
        .fpu_result  (fpu_result),
        .fpu_flags   (fpu_flags),
        .fpu_valid_i (fpu_valid_i)
`ifdef FPU_WB_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail = 0;

    // start-pulse monitor: counts pulses and snapshots what the FPU would sample
    int          pulse_cnt = 0;
    int          last_pulse = -100;
    logic [31:0] cap_a, cap_b, cap_c;
    logic [2:0]  cap_rm;
    logic [11:0] cap_op;
    always @(negedge clk) begin
        if (fpu_valid_o === 1'b1) begin
            pulse_cnt++;
            last_pulse = cycle;
            cap_a  = fpu_a;
            cap_b  = fpu_b;
            cap_c  = fpu_c;
            cap_rm = fpu_rm;
            cap_op = fpu_op;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [7:0] off, input logic [3:0] sel,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int req_cyc);
        @(posedge clk); #1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = BASE | {24'd0, off};
        bus.wbs_dat_i = wdata;
        req_cyc = cycle;
        @(posedge clk); #1;
        chk($sformatf("ack_%02h", off), 32'(bus.wbs_ack_o), 32'd1);
        rdata = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("ack_drop_%02h", off), 32'(bus.wbs_ack_o), 32'd0);
        chk($sformatf("dat_idle_%02h", off), bus.wbs_dat_o, 32'd0);
    endtask

    task automatic wr32(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] rd;
        int rc;
        xfer(1'b1, off, 4'hF, d, rd, rc);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int rc;
        xfer(1'b0, off, 4'hF, 32'd0, rd, rc);
        chk(name, rd, exp);
    endtask

    task automatic respond(input int lat, input logic [31:0] res, input logic [4:0] flg);
        repeat (lat) @(posedge clk);
        #1;
        fpu_valid_i = 1'b1;
        fpu_result  = res;
        fpu_flags   = flg;
        @(posedge clk); #1;
        fpu_valid_i = 1'b0;
        fpu_result  = $urandom();
        fpu_flags   = 5'($urandom());
    endtask

    task automatic chk_irq(input string name, input logic exp);
`ifdef FPU_WB_IRQ_EN
        chk(name, 32'(irq), 32'(exp));
`endif
    endtask

    // register-map level reference model
    logic [31:0] m_a, m_b, m_c, m_res;
    logic [4:0]  m_flags;
    logic [2:0]  m_rm;
    logic [11:0] m_op;
    logic        m_irqen, m_done, m_err;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_res = 0; m_flags = 0;
        m_rm = 0; m_op = 0; m_irqen = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return m_a;
            8'h04: return m_b;
            8'h08: return m_c;
            8'h0C: return m_res;
            8'h10: return {27'd0, m_flags};
            8'h14: return {29'd0, m_err, m_done, 1'b0};
            8'h18: return {31'd0, m_irqen};
            8'h1C: return {20'd0, m_op};
            8'h24: return {29'd0, m_rm};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] old_v, new_v;
        old_v = model_read(off);
        new_v = old_v;
        for (int i = 0; i < 4; i++) if (sel[i]) new_v[8*i +: 8] = d[8*i +: 8];
        case (off)
            8'h00: m_a = new_v;
            8'h04: m_b = new_v;
            8'h08: m_c = new_v;
            8'h1C: m_op = new_v[11:0];
            8'h24: m_rm = new_v[2:0];
            8'h18: begin
                if (sel[0] && d[1]) begin m_done = 0; m_err = 0; end
                m_irqen = IRQ_BUILD ? new_v[0] : 1'b0;
            end
            default: ;
        endcase
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic we, input logic [7:0] off, input logic [3:0] sel,
                                input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.off = off; v.sel = sel; v.wdata = wdata; v.exp = exp;
        tbl.push_back(v);
    endfunction

    logic [7:0] offs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                              8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h3C};

    initial begin
        logic [31:0] rd, wd, res;
        logic [3:0]  acks, sel;
        logic [7:0]  off;
        logic [4:0]  flg;
        int          rc, p0, kind, lat, exp_pulses;

        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_valid", 32'(fpu_valid_o), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk_irq("rst_irq", 1'b0);

        for (int i = 0; i <= 9; i++) add(0, 8'(4 * i), 4'hF, 0, 0);
        add(0, 8'h28, 4'hF, 0, 0);
        add(0, 8'h3C, 4'hF, 0, 0);
        add(1, 8'h00, 4'hF, 32'h3F80_0000, 0); add(0, 8'h00, 4'hF, 0, 32'h3F80_0000);
        add(1, 8'h04, 4'hF, 32'h4000_0000, 0); add(0, 8'h04, 4'hF, 0, 32'h4000_0000);
        add(1, 8'h08, 4'hF, 32'h1234_5678, 0); add(0, 8'h08, 4'hF, 0, 32'h1234_5678);
        add(1, 8'h0C, 4'hF, 32'hFFFF_FFFF, 0); add(0, 8'h0C, 4'hF, 0, 0);
        add(1, 8'h10, 4'hF, 32'hFFFF_FFFF, 0); add(0, 8'h10, 4'hF, 0, 0);
        add(1, 8'h14, 4'hF, 32'hFFFF_FFFF, 0); add(0, 8'h14, 4'hF, 0, 0);
        add(1, 8'h20, 4'hF, 32'hFFFF_FFFF, 0); add(0, 8'h20, 4'hF, 0, 0);
        add(1, 8'h24, 4'hF, 32'hFFFF_FFFF, 0); add(0, 8'h24, 4'hF, 0, 32'd7);
        add(1, 8'h24, 4'hE, 32'h0000_0000, 0); add(0, 8'h24, 4'hF, 0, 32'd7);
        add(1, 8'h1C, 4'hF, 32'h0000_0ABC, 0); add(0, 8'h1C, 4'hF, 0, 32'h0000_0ABC);
        add(1, 8'h1C, 4'h1, 32'h0000_00FF, 0); add(0, 8'h1C, 4'hF, 0, 32'h0000_0AFF);
        add(1, 8'h18, 4'hF, 32'h0000_0003, 0); add(0, 8'h18, 4'hF, 0, IRQ_BUILD ? 32'd1 : 32'd0);
        add(1, 8'h18, 4'hF, 32'h0000_0000, 0); add(0, 8'h18, 4'hF, 0, 0);
        add(1, 8'h00, 4'hF, 32'h1111_1111, 0);
        add(1, 8'h00, 4'h3, 32'hDEAD_BEEF, 0); add(0, 8'h00, 4'hF, 0, 32'h1111_BEEF);
        add(1, 8'h00, 4'hC, 32'hCAFE_0000, 0); add(0, 8'h00, 4'hF, 0, 32'hCAFE_BEEF);
        foreach (tbl[i]) begin
            xfer(tbl[i].we, tbl[i].off, tbl[i].sel, tbl[i].wdata, rd, rc);
            if (!tbl[i].we) chk($sformatf("vec%0d_rd_%02h", i, tbl[i].off), rd, tbl[i].exp);
        end
        chk("vec_no_pulse", 32'(pulse_cnt), 32'd0);

        // address miss and cyc low must never be acknowledged
        @(posedge clk); #1;
        bus.wbs_stb_i = 1; bus.wbs_cyc_i = 1; bus.wbs_adr_i = BASE + 32'h100;
        repeat (2) begin @(posedge clk); #1; chk("miss_no_ack", 32'(bus.wbs_ack_o), 32'd0); end
        bus.wbs_cyc_i = 0; bus.wbs_adr_i = BASE;
        repeat (2) begin @(posedge clk); #1; chk("nocyc_no_ack", 32'(bus.wbs_ack_o), 32'd0); end
        // strobe held high: acks must alternate with idle cycles
        bus.wbs_cyc_i = 1;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; acks[i] = bus.wbs_ack_o; end
        bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0;
        chk("held_stb_ack_pattern", 32'(acks), 32'h5);
        repeat (2) @(posedge clk);

        // basic issue / complete
        wr32(8'h18, 32'h1);
        wr32(8'h00, 32'h3F80_0000);
        wr32(8'h04, 32'h4000_0000);
        wr32(8'h24, 32'h0);
        chk("op1_fpu_a", fpu_a, 32'h3F80_0000);
        chk("op1_fpu_b", fpu_b, 32'h4000_0000);
        chk("op1_fpu_rm", 32'(fpu_rm), 32'd0);
        p0 = pulse_cnt;
        xfer(1'b1, 8'h1C, 4'hF, 32'h0000_1001, rd, rc);
        @(negedge clk); #1;
        chk("op1_fpu_op", 32'(fpu_op), 32'h001);
        chk("op1_pulse_cnt", 32'(pulse_cnt - p0), 32'd1);
        chk("op1_pulse_latency", 32'(last_pulse - rc), 32'd2);
        rd_chk("op1_status_busy", 8'h14, 32'h1);
        respond(4, 32'h4040_0000, 5'b00001);
        repeat (2) @(posedge clk); #1;
        chk_irq("op1_irq", 1'b1);
        rd_chk("op1_result", 8'h0C, 32'h4040_0000);
        rd_chk("op1_flags", 8'h10, 32'h01);
        rd_chk("op1_status_done", 8'h14, 32'h2);
        chk("op1_single_pulse", 32'(pulse_cnt - p0), 32'd1);

        // second issue, then a rejected issue while busy
        xfer(1'b1, 8'h1C, 4'hF, 32'h0000_1002, rd, rc);
        @(negedge clk); #1;
        chk("op2_pulse_cnt", 32'(pulse_cnt - p0), 32'd2);
        chk("op2_fpu_op", 32'(fpu_op), 32'h002);
        xfer(1'b1, 8'h1C, 4'hF, 32'h0000_1FFF, rd, rc);
        repeat (3) @(posedge clk); #1;
        chk("busy_issue_no_pulse", 32'(pulse_cnt - p0), 32'd2);
        chk("busy_issue_op_kept", 32'(fpu_op), 32'h002);
        rd_chk("busy_status", 8'h14, 32'h5);
        respond(2, 32'h1234_0000, 5'b10000);
        rd_chk("op2_status", 8'h14, 32'h6);
        wr32(8'h18, 32'h2);
        rd_chk("clear_status", 8'h14, 32'h0);
        repeat (2) @(posedge clk); #1;
        chk_irq("clear_irq", 1'b0);

        // reset while waiting for the FPU; the late result must be dropped
        wr32(8'h18, 32'h1);
        p0 = pulse_cnt;
        xfer(1'b1, 8'h1C, 4'hF, 32'h0000_1003, rd, rc);
        @(negedge clk); #1;
        chk("rstwait_pulse", 32'(pulse_cnt - p0), 32'd1);
        @(posedge clk); #1 rst_l = 1'b0;
        @(posedge clk); #1 rst_l = 1'b1;
        chk("rstwait_valid_low", 32'(fpu_valid_o), 32'd0);
        respond(1, 32'hDEAD_BEEF, 5'h1F);
        repeat (2) @(posedge clk); #1;
        chk_irq("rstwait_irq", 1'b0);
        chk("rstwait_no_pulse", 32'(pulse_cnt - p0), 32'd1);
        rd_chk("rstwait_status", 8'h14, 32'h0);
        rd_chk("rstwait_result", 8'h0C, 32'h0);
        rd_chk("rstwait_flags", 8'h10, 32'h0);
        rd_chk("rstwait_a", 8'h00, 32'h0);
        rd_chk("rstwait_ctrl", 8'h18, 32'h0);

        // randomized traffic against the register-map model
        model_reset();
        exp_pulses = pulse_cnt;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                off = offs[$urandom_range(0, 11)];
                sel = 4'($urandom());
                wd  = $urandom();
                if (off == 8'h1C) wd[12] = 1'b0;
                if (kind <= 3) begin
                    xfer(1'b1, off, sel, wd, rd, rc);
                    model_write(off, sel, wd);
                    chk("rnd_fpu_a", fpu_a, m_a);
                    chk("rnd_fpu_b", fpu_b, m_b);
                    chk("rnd_fpu_c", fpu_c, m_c);
                    chk("rnd_fpu_rm", 32'(fpu_rm), 32'(m_rm));
                    chk("rnd_fpu_op", 32'(fpu_op), 32'(m_op));
                end else begin
                    xfer(1'b0, off, 4'hF, 32'd0, rd, rc);
                    chk($sformatf("rnd_rd_%02h", off), rd, model_read(off));
                end
            end else begin
                sel = 4'($urandom()) | 4'b0010;
                wd  = $urandom();
                wd[12] = 1'b1;
                model_write(8'h1C, sel, wd);
                m_done = 1'b0;
                exp_pulses++;
                xfer(1'b1, 8'h1C, sel, wd, rd, rc);
                @(negedge clk); #1;
                chk("rnd_pulse_cnt", 32'(pulse_cnt), 32'(exp_pulses));
                chk("rnd_pulse_latency", 32'(last_pulse - rc), 32'd2);
                chk("rnd_cap_a", cap_a, m_a);
                chk("rnd_cap_b", cap_b, m_b);
                chk("rnd_cap_c", cap_c, m_c);
                chk("rnd_cap_rm", 32'(cap_rm), 32'(m_rm));
                chk("rnd_cap_op", 32'(cap_op), 32'(m_op));
                lat = $urandom_range(1, 5);
                res = $urandom();
                flg = 5'($urandom());
                respond(lat, res, flg);
                m_res = res; m_flags = flg; m_done = 1'b1;
                repeat (2) @(posedge clk); #1;
                chk_irq("rnd_irq", m_done & m_irqen);
                rd_chk("rnd_result", 8'h0C, model_read(8'h0C));
                rd_chk("rnd_flags", 8'h10, model_read(8'h10));
                rd_chk("rnd_status", 8'h14, model_read(8'h14));
            end
        end
        chk("rnd_total_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
